resp_tx_arb: RTL and testbench

- Shares the single UART response transmitter among NUM_REQ requesters.
- Each requester presents a 1- or 2-byte response. The block grants one requester, serialises its bytes onto resp_trmt/resp_tx_data, and waits on resp_tx_done between bytes.
- It pulses a per-requester ack when the response is fully sent.
- It sits between the command processor, the tour/telemetry logic and the UART wrapper's transmit side.

---
 rtl/resp_tx_arb.sv | 134 +++++++++++++
 tb/tb_resp_tx_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_tx_arb.sv
// resp_tx_arb: shares the UART response transmitter among NUM_REQ requesters, sending 1- or 2-byte responses.
// Define RESP_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module resp_tx_arb #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_len,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   resp_trmt,
    output logic [7:0]             resp_tx_data,
    input  logic                   resp_tx_done
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    state_t               state_q, state_d;
    logic [15:0]          shift_q, shift_d;
    logic [1:0]           left_q, left_d;
    logic                 first_q, first_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 trmt_q, trmt_d;
    logic [7:0]           data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]     win, cand;
    logic [15:0]          win_data;
`ifdef RESP_RR_ARB_EN
    logic [IDX_W-1:0]     rr_q, rr_d;
`endif
    // Scan from the far end so the first hit in priority order is the last assignment.
    always_comb begin
        win = '0;
        cand = '0;
`ifdef RESP_RR_ARB_EN
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (req[cand]) win = cand;
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) win = cand;
        end
`endif
    end
    assign win_data = req_data[{win, 4'h0} +: 16];
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        left_d  = left_q;
        first_d = 1'b0;
        grant_d = grant_q;
        busy_d  = busy_q;
        trmt_d  = 1'b0;
        data_d  = data_q;
        ack_d   = '0;
`ifdef RESP_RR_ARB_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: if (|req) begin
                state_d = SEND;
                shift_d = win_data;
                left_d  = req_len[win] ? 2'd2 : 2'd1;
                grant_d = win;
                busy_d  = 1'b1;
                trmt_d  = 1'b1;
                data_d  = req_len[win] ? win_data[15:8] : win_data[7:0];
            end
            SEND: begin
                state_d = WAIT;
                left_d  = left_q - 2'd1;
                first_d = 1'b1;
            end
            // The first WAIT cycle may still see the previous byte's done level.
            WAIT: if (!first_q && resp_tx_done) begin
                if (left_q != 2'd0) begin
                    state_d = SEND;
                    trmt_d  = 1'b1;
                    data_d  = (left_q == 2'd2) ? shift_q[15:8] : shift_q[7:0];
                end else begin
                    state_d = DONE;
                    ack_d[grant_q] = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef RESP_RR_ARB_EN
                rr_d    = grant_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            left_q  <= '0;
            first_q <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            trmt_q  <= 1'b0;
            data_q  <= '0;
            ack_q   <= '0;
`ifdef RESP_RR_ARB_EN
            rr_q    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            left_q  <= left_d;
            first_q <= first_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            trmt_q  <= trmt_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
`ifdef RESP_RR_ARB_EN
            rr_q    <= rr_d;
`endif
        end
    end
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign grant_idx    = grant_q;
    assign resp_trmt    = trmt_q;
    assign resp_tx_data = data_q;
endmodule

// File: tb/tb_resp_tx_arb.sv
// tb_resp_tx_arb: scoreboard bench for resp_tx_arb with a simple UART transmit model.
module tb_resp_tx_arb;
    localparam int N = 3;
    localparam int IW = $clog2(N);
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]    req_len = '0;
    logic [N-1:0]    ack;
    logic            busy;
    logic [IW-1:0]   grant_idx;
    logic            resp_trmt;
    logic [7:0]      resp_tx_data;
    logic            resp_tx_done = 1'b1;
    resp_tx_arb #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
        .ack(ack), .busy(busy), .grant_idx(grant_idx), .resp_trmt(resp_trmt),
        .resp_tx_data(resp_tx_data), .resp_tx_done(resp_tx_done)
    );
    always #5 clk = ~clk;
    typedef struct { int g; int b; } exp_t;
    exp_t byte_q[$];
    int   ack_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   rr_m = N - 1;
    int   lat = 3;
    bit   stale = 1'b0;
    int   cnt = 0;
    bit   clr_pend = 1'b0;
    logic [N-1:0] prev_ack = '0;
    logic prev_done = 1'b0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // UART model: done drops on trmt (one cycle late in stale mode) and rises lat cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_tx_done <= 1'b1;
            cnt <= 0;
            clr_pend <= 1'b0;
        end else if (resp_trmt) begin
            cnt <= lat;
            clr_pend <= stale;
            if (!stale) resp_tx_done <= 1'b0;
        end else if (clr_pend) begin
            resp_tx_done <= 1'b0;
            clr_pend <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) resp_tx_done <= 1'b1;
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_trmt) begin
                check("uart_idle", 32'((cnt != 0) || clr_pend), 0);
                if (byte_q.size() == 0) check("trmt_unexp", 1, 0);
                else begin
                    e = byte_q.pop_front();
                    check("tx_data", resp_tx_data, e.b);
                    check("grant_idx", grant_idx, e.g);
                    check("busy_tx", busy, 1);
                end
            end
            if (|ack) begin
                check("ack_lat", prev_done, 1);
                check("busy_ack", busy, 1);
                if (ack_q.size() == 0) check("ack_unexp", ack, 0);
                else check("ack", ack, 1 << ack_q.pop_front());
            end
            if (|prev_ack) check("busy_drop", busy, 0);
        end
        prev_ack = ack;
        prev_done = resp_tx_done;
    end
    function automatic int pick(logic [N-1:0] m);
`ifdef RESP_RR_ARB_EN
        for (int k = 1; k <= N; k++) if (m[(rr_m + k) % N]) return (rr_m + k) % N;
`else
        for (int i = 0; i < N; i++) if (m[i]) return i;
`endif
        return 0;
    endfunction
    task automatic set_req(int i, logic [15:0] d, logic l);
        req_data[16*i +: 16] = d;
        req_len[i] = l;
    endtask
    task automatic push(int g);
        logic [15:0] d;
        d = req_data[16*g +: 16];
        if (req_len[g]) byte_q.push_back('{g: g, b: int'(d[15:8])});
        byte_q.push_back('{g: g, b: int'(d[7:0])});
        ack_q.push_back(g);
        rr_m = g;
    endtask
    task automatic push_all(logic [N-1:0] m);
        int g;
        while (m != '0) begin
            g = pick(m);
            push(g);
            m[g] = 1'b0;
        end
    endtask
    // stop_at==0: each requester drops its req on ack; otherwise all req held until stop_at acks.
    task automatic run(int stop_at);
        int acks = 0;
        bit done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(posedge clk); #1;
            if (|ack) begin
                acks++;
                if (stop_at == 0) req &= ~ack;
                else if (acks == stop_at) req = '0;
            end
            if (byte_q.size() == 0 && ack_q.size() == 0 && !busy && req == '0) done = 1'b1;
        end
        if (!done) begin
            check("run_timeout", 0, 1);
            byte_q.delete();
            ack_q.delete();
            req = '0;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_trmt", resp_trmt, 0);
        check("rst_data", resp_tx_data, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_done_high", resp_trmt, 0);
        set_req(0, 16'hA55A, 1'b1);
        req = 3'b001;
        push_all(req);
        @(posedge clk); #1;
        check("trmt_lat", resp_trmt, 1);
        run(0);
        set_req(1, 16'h12C3, 1'b0);
        req = 3'b010;
        push_all(req);
        run(0);
        stale = 1'b1;
        set_req(2, 16'h3C96, 1'b1);
        req = 3'b100;
        push_all(req);
        run(0);
        stale = 1'b0;
        set_req(0, 16'h1111, 1'b0);
        set_req(1, 16'h2233, 1'b1);
        set_req(2, 16'h0044, 1'b0);
        req = 3'b111;
        for (int n = 0; n < 4; n++) push(pick(req));
        run(4);
        set_req(1, 16'h5566, 1'b1);
        req = 3'b010;
        push_all(req);
        for (int c = 0; c < 20 && !busy; c++) begin
            @(posedge clk); #1;
        end
        req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        run(0);
        set_req(0, 16'hBEEF, 1'b1);
        req = 3'b001;
        push_all(req);
        for (int c = 0; c < 20 && !resp_trmt; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_trmt", resp_trmt, 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant_idx, 0);
        check("mid_rst_data", resp_tx_data, 0);
        byte_q.delete();
        ack_q.delete();
        rr_m = N - 1;
        set_req(1, 16'h0077, 1'b0);
        req = 3'b011;
        @(negedge clk);
        rst_n = 1'b1;
        push_all(req);
        run(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
